// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, byte type and receive-buffer defaults.
package uart_pkg;

  localparam int unsigned UART_DATA_W            = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH     = 16;
  localparam int unsigned UART_RX_TIMEOUT_CYCLES = 1024;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage: registered write port, asynchronous read for fall-through.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);

  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected push, valid/ready pop, sticky overflow, occupancy.
// Optional idle-data timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = UART_RX_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = UART_RX_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_Rx_Done,
  input  logic [7:0]               i_Rx_Byte,
  output logic                     o_Rd_Valid,
  input  logic                     i_Rd_Ready,
  output logic [7:0]               o_Rd_Byte,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic                     o_Overflow,
  input  logic                     i_Ovf_Clr,
  output logic                     o_Timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          done_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          push_req, push, pop, drop;
  uart_byte_t    rdata;

  assign o_Empty    = (count_q == '0);
  assign o_Full     = (count_q == CW'(DEPTH));
  assign o_Count    = count_q;
  assign o_Rd_Valid = !o_Empty;
  assign o_Overflow = ovf_q;
  assign o_Rd_Byte  = o_Empty ? '0 : rdata;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push_req = i_Rx_Done && !done_q;
  assign pop      = o_Rd_Valid && i_Rd_Ready;
  assign push     = push_req && (!o_Full || pop);
  assign drop     = push_req && o_Full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q  <= i_Rx_Done;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)           ovf_q <= 1'b1;
      else if (i_Ovf_Clr) ovf_q <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (i_Rx_Byte),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (push || o_Empty) begin
      idle_d = '0;
    end else if (idle_q != TW'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign o_Timeout = (idle_q == TW'(TIMEOUT_CYCLES)) && !o_Empty;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign o_Timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, TIMEOUT_CYCLES=8).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx_done, rd_ready, ovf_clr;
  logic [7:0] rx_byte;
  logic       rd_valid, full, empty, overflow, timeout;
  logic [7:0] rd_byte;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Rx_Done  (rx_done),
    .i_Rx_Byte  (rx_byte),
    .o_Rd_Valid (rd_valid),
    .i_Rd_Ready (rd_ready),
    .o_Rd_Byte  (rd_byte),
    .o_Count    (count),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Overflow (overflow),
    .i_Ovf_Clr  (ovf_clr),
    .o_Timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b1; rd_ready = 1'b0; ovf_clr = 1'b0; rx_byte = 8'hEE;
    tick(3);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_tmo", 32'(timeout), 0);
    check("rst_byte", 32'(rd_byte), 0);

    // Release reset while strobe still high: no push.
    reset = 1'b0;
    tick(2);
    check("rel_empty", 32'(empty), 1);
    check("rel_count", 32'(count), 0);
    rx_done = 1'b0;
    tick();

    // Strobe held 3 cycles produces one entry.
    rx_byte = 8'hA5; rx_done = 1'b1;
    tick();
    check("a5_valid", 32'(rd_valid), 1);
    check("a5_byte", 32'(rd_byte), 32'h A5);
    tick(2);
    check("a5_count", 32'(count), 1);
    rx_done = 1'b0;
    tick();
    check("a5_count2", 32'(count), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("a5_drained", 32'(empty), 1);

    // Ready while empty has no effect.
    rd_ready = 1'b1;
    tick();
    check("rdy_empty_cnt", 32'(count), 0);
    // Push while empty with ready high: pushed, popped next cycle.
    rx_byte = 8'h3C; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("pe_count", 32'(count), 1);
    check("pe_byte", 32'(rd_byte), 32'h3C);
    tick();
    check("pe_popped", 32'(count), 0);
    rd_ready = 1'b0;

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_ovf", 32'(overflow), 0);
    push_byte(8'h55);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(rd_byte), 32'(i));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    check("drain_empty", 32'(empty), 1);
    check("drain_valid", 32'(rd_valid), 0);

    // Refill; clear coinciding with a drop keeps overflow set.
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    rx_byte = 8'h66; rx_done = 1'b1; ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    check("clr_vs_drop", 32'(overflow), 1);
    tick();
    ovf_clr = 1'b0;
    check("clr_alone", 32'(overflow), 0);
    check("clr_count", 32'(count), 16);

    // Push and pop together while full.
    rx_byte = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rx_done = 1'b0; rd_ready = 1'b0;
    check("pp_count", 32'(count), 16);
    check("pp_ovf", 32'(overflow), 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("wrap_%0d", i), 32'(rd_byte), 32'(8'h11 + i));
      rd_ready = 1'b1;
      tick();
    end
    check("wrap_last", 32'(rd_byte), 32'h77);
    tick();
    rd_ready = 1'b0;
    check("wrap_empty", 32'(empty), 1);

    // Idle timeout.
    push_byte(8'h99);
`ifdef UART_RX_TIMEOUT_EN
    // push_byte already spent one cycle after the push edge.
    tick(6);
    check("tmo_before", 32'(timeout), 0);
    tick();
    check("tmo_at", 32'(timeout), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("tmo_pop", 32'(timeout), 0);
`else
    tick(12);
    check("tmo_off", 32'(timeout), 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
`endif
    check("final_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART controller's receive path.
- Captures each byte announced by the controller's one-byte-done pulse into a DEPTH-entry first-word-fall-through FIFO.
- Presents the bytes to the host/bus side on a valid/ready read interface, with a sticky overflow flag and occupancy count.
- Decouples host read latency from line rate, so back-to-back frames are not lost.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2
TIMEOUT_CYCLES, 1024, idle clk cycles before o_Timeout asserts (used only with UART_RX_TIMEOUT_EN); minimum 1

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_Rx_Done  input  1  byte-received strobe from controller; may be held high more than one cycle
i_Rx_Byte  input  8  received byte; stable while i_Rx_Done is high
o_Rd_Valid  output  1  head entry available (equals !o_Empty)
i_Rd_Ready  input  1  host accepts head entry
o_Rd_Byte  output  8  head entry; meaningful only when o_Rd_Valid=1
o_Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_Full  output  1  o_Count==DEPTH
o_Empty  output  1  o_Count==0
o_Overflow  output  1  sticky: a byte was dropped because the FIFO was full
i_Ovf_Clr  input  1  clears o_Overflow
o_Timeout  output  1  idle-data flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): rd/wr pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Rd_Valid 0, o_Overflow 0, o_Timeout 0, o_Rd_Byte 0.
- Reset loads the done-edge register with 1, so an i_Rx_Done already high at reset release does not create a push.
- Reset mid-operation discards all stored bytes; storage contents need not be cleared.
- Push: occurs on the rising edge of i_Rx_Done (current=1, registered previous=0), once per strobe regardless of strobe width.
  - Byte pushed in cycle N is visible with o_Rd_Valid=1 in cycle N+1 when the FIFO was empty.
- Pop: occurs on any cycle with o_Rd_Valid && i_Rd_Ready; the next entry (or o_Rd_Valid=0) appears the following cycle.
- i_Rd_Ready while empty: no effect.
- Push and pop in the same cycle:
  - Not full: both occur; count unchanged.
  - Full: both occur; count stays DEPTH; no overflow.
  - Empty: pop is not possible (valid=0); push occurs; count becomes 1.
- Push while full without pop: byte dropped, storage and count unchanged, o_Overflow set next cycle.
- o_Overflow holds until a cycle with i_Ovf_Clr=1. If i_Ovf_Clr and a new drop coincide, set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from the count register, not pointer compare.
- All status outputs are registered or pure decodes of registers; no combinational path from i_Rd_Ready to any output.

Optional Feature:
Macro: UART_RX_TIMEOUT_EN
- Defined:
  - Idle counter resets to 0 on any push, and holds at 0 while the FIFO is empty.
  - Otherwise it increments each cycle, saturating at TIMEOUT_CYCLES.
  - o_Timeout=1 while counter==TIMEOUT_CYCLES and FIFO non-empty.
  - o_Timeout clears the cycle after a push or after the FIFO becomes empty.
  - Pops alone do not reset the counter.
- Not defined: no counter logic; o_Timeout tied to 0; port list unchanged.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8
  - byte typedef uart_byte_t
  - default UART_RX_FIFO_DEPTH=16 and UART_RX_TIMEOUT_CYCLES=1024
- One sub-module, uart_fifo_mem: DEPTH x 8 storage with registered write port (we, waddr, wdata) and asynchronous read (raddr -> rdata) for fall-through.
- Pointer, count, flag and timeout logic stay in uart_rx_fifo.

Test Plan:
- Reset with i_Rx_Done held high, then release -> no push; o_Empty=1, o_Count=0.
- Pulse i_Rx_Done with byte 0xA5, held 3 cycles, i_Rd_Ready=0 -> exactly one entry; o_Rd_Valid=1 next cycle, o_Rd_Byte=0xA5, o_Count=1.
- Push 0x00..0x0F (DEPTH=16), then push 0x55 -> o_Full=1, 0x55 dropped, o_Overflow=1. Drain -> bytes 0x00..0x0F in order, o_Empty=1.
- Full FIFO; in the same cycle push 0x77 and pop with i_Rd_Ready=1 -> no overflow, o_Count=16, 0x77 read last after wrap.
- o_Overflow=1; assert i_Ovf_Clr together with a drop -> o_Overflow stays 1. Clear alone next cycle -> 0.
- UART_RX_TIMEOUT_EN, TIMEOUT_CYCLES=8: push one byte, no reads -> o_Timeout=1 exactly 8 cycles after the push cycle. Pop it -> o_Timeout=0 next cycle.
